// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch. Issues fetch requests
// over a valid/ready channel, buffers in-order responses in a DEPTH-entry
// queue and hands them to decode. Handles branch redirects by dropping
// stale responses, and drains with NOPs once the halt word reaches the head.
module instr_fetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        prog_done,
    output logic [31:0] fetch_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Stale responses can pile up across back-to-back redirects, so this
    // counter is much wider than the outstanding-request counter.
    localparam int SW = 16;
    localparam int NW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, HALTED, DRAIN, DONE} state_t;

    state_t        state, nextState;
    logic [31:0]   qPc   [DEPTH];
    logic [31:0]   qWord [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr, issueIdx;
    logic [CW-1:0] occupancy, outstanding;
    logic [SW-1:0] stale, inFlight;
    logic [31:0]   memAddr, haltPc, fetchCount;
    logic [NW-1:0] nopCount;

    logic fetching, redirectTaken, empty, headIsHalt;
    logic reqFire, rspFresh, rspDrop, rspWrite;
    logic deliver, deq, enterDrain;
    logic unusedAddrBits;

    assign unusedAddrBits = ^redirect_pc[1:0];

    // Request/response bookkeeping shared by the FSM and the queue.
    always_comb begin
        fetching      = (state == FETCH) || (state == HALTED);
        redirectTaken = redirect && fetching;
        empty         = (occupancy == '0);
        headIsHalt    = !empty && (qWord[rdPtr] == HALT_WORD);
        mem_req_valid = (state == FETCH) && pc_en && !redirect &&
                        (({1'b0, occupancy} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
        reqFire       = mem_req_valid && mem_req_ready;
        rspDrop       = mem_rsp_valid && !redirectTaken && (stale != '0);
        rspFresh      = mem_rsp_valid && !redirectTaken && (stale == '0) && (outstanding != '0);
        rspWrite      = rspFresh && fetching;
        // Slots for outstanding requests are reserved right behind the
        // written data, so the issue slot is wrPtr + outstanding.
        issueIdx      = wrPtr + outstanding[AW-1:0];
        inFlight      = stale + SW'(outstanding) + SW'(reqFire);
    end

    // Next-state and CPU-facing outputs.
    always_comb begin
        nextState  = state;
        inst_valid = 1'b0;
        inst       = qWord[rdPtr];
        inst_pc    = qPc[rdPtr];
        case (state)
            IDLE: begin
                if (pc_en) nextState = FETCH;
            end
            FETCH: begin
                inst_valid = !empty && !headIsHalt;
                if (!redirectTaken && rspWrite && (mem_rsp_data == HALT_WORD))
                    nextState = HALTED;
            end
            HALTED: begin
                // The halt word itself is never shown to decode.
                inst_valid = !empty && !headIsHalt;
                if (redirectTaken)   nextState = FETCH;
                else if (headIsHalt) nextState = DRAIN;
            end
            DRAIN: begin
                inst_valid = 1'b1;
                inst       = NOP_WORD;
                inst_pc    = haltPc;
                if (inst_ready && (nopCount == NW'(FLUSH_CYCLES - 1)))
                    nextState = DONE;
            end
            DONE: begin
                nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    // A redirect wins over a same-cycle handshake: nothing is dequeued or counted.
    assign deliver    = inst_valid && inst_ready && !redirectTaken;
    assign deq        = deliver && fetching;
    assign enterDrain = (state == HALTED) && (nextState == DRAIN);

    assign mem_addr    = memAddr;
    assign prog_done   = (state == DONE);
    assign fetch_count = fetchCount;

    // Pointers, occupancy, outstanding/stale counters and fetch address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            stale       <= '0;
            memAddr     <= RESET_PC;
        end else if (redirectTaken) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            // Everything still in flight becomes stale, less a response
            // that lands (and is dropped) in this very cycle.
            stale       <= (mem_rsp_valid && (inFlight != '0)) ? inFlight - SW'(1) : inFlight;
            memAddr     <= {redirect_pc[31:2], 2'b00};
        end else begin
            if (reqFire) memAddr <= memAddr + 32'd4;
            if (rspDrop) stale   <= stale - SW'(1);
            outstanding <= outstanding + CW'(reqFire) - CW'(rspFresh);
            if (enterDrain) begin
                // Anything queued behind the halt word is discarded.
                rdPtr     <= '0;
                wrPtr     <= '0;
                occupancy <= '0;
            end else begin
                if (rspWrite) wrPtr <= wrPtr + AW'(1);
                if (deq)      rdPtr <= rdPtr + AW'(1);
                occupancy <= occupancy + CW'(rspWrite) - CW'(deq);
            end
        end
    end

    // Queue storage: pc tagged at issue, word filled on response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                qPc[i]   <= '0;
                qWord[i] <= '0;
            end
        end else begin
            if (reqFire)  qPc[issueIdx] <= memAddr;
            if (rspWrite) qWord[wrPtr]  <= mem_rsp_data;
        end
    end

    // State register, drain bookkeeping and delivery counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            haltPc     <= '0;
            nopCount   <= '0;
            fetchCount <= '0;
        end else begin
            state <= nextState;
            if (enterDrain)                    haltPc     <= qPc[rdPtr];
            if ((state == DRAIN) && inst_ready) nopCount   <= nopCount + NW'(1);
            if (deliver)                       fetchCount <= fetchCount + 32'd1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: in-order memory model with
// configurable latency, table-driven halt/drain runs plus hand sequences.
module tb_instr_fetch_queue;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        readyReq = 1'b1;
    logic        throttle = 1'b0;
    logic        phase = 1'b0;
    wire         inst_ready = throttle ? phase : readyReq;
    wire         mem_req_valid, inst_valid, prog_done;
    wire  [31:0] mem_addr, inst, inst_pc, fetch_count;

    instr_fetch_queue dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .prog_done(prog_done), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int lat    = 1;
    logic        haltEn = 1'b0;
    logic [31:0] haltAddr = 32'h0;
    logic        haltSeen = 1'b0;
    int          reqAfterHalt = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] reqLog[$];
    logic [31:0] delInst[$];
    logic [31:0] delPc[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (haltEn && (a == haltAddr)) return HALT;
        return 32'h1000_0000 | ((a >> 2) + 32'd1);
    endfunction

    // Monitor: log handshakes at the active edge, feed the memory model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            pend.delete();
            haltSeen     <= 1'b0;
            reqAfterHalt <= 0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                if (haltSeen) reqAfterHalt <= reqAfterHalt + 1;
                pend.push_back('{mem_addr, cyc + lat});
                reqLog.push_back(mem_addr);
            end
            if (mem_rsp_valid && (mem_rsp_data == HALT)) haltSeen <= 1'b1;
            if (inst_valid && inst_ready) begin
                delInst.push_back(inst);
                delPc.push_back(inst_pc);
            end
        end
    end

    // Memory model: in-order responses, driven away from the active edge.
    always @(negedge clk) begin
        phase <= ~phase;
        if (reset || (pend.size() == 0) || (pend[0].due > cyc)) begin
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= 32'h0;
        end else begin
            mem_rsp_valid <= 1'b1;
            mem_rsp_data  <= memWord(pend[0].addr);
            pend.pop_front();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic doReset();
        reset = 1'b1; pc_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        readyReq = 1'b1; throttle = 1'b0;
        repeat (2) @(negedge clk);
        reqLog.delete(); delInst.delete(); delPc.delete();
        reset = 1'b0;
    endtask

    task automatic waitDel(input int n, input int budget, input string name);
        int k = 0;
        while ((delInst.size() < n) && (k < budget)) begin @(posedge clk); #1; k++; end
        if (delInst.size() < n) timeoutFail(name);
    endtask

    task automatic waitReq(input int n, input int budget, input string name);
        int k = 0;
        while ((reqLog.size() < n) && (k < budget)) begin @(posedge clk); #1; k++; end
        if (reqLog.size() < n) timeoutFail(name);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] haltAddr;
        logic        throttle;
        int          expCount;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{1, 32'h0000_0008, 1'b0, 5};
        vecs[1] = '{3, 32'h0000_0008, 1'b0, 5};
        vecs[2] = '{1, 32'h0000_0000, 1'b0, 3};
        vecs[3] = '{2, 32'h0000_0014, 1'b0, 8};
        vecs[4] = '{2, 32'h0000_0010, 1'b1, 7};

        // Reset state.
        #1;
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_addr",      mem_addr, 32'h0);
        chk("rst inst_valid",    32'(inst_valid), 32'd0);
        chk("rst inst",          inst, 32'h0);
        chk("rst inst_pc",       inst_pc, 32'h0);
        chk("rst prog_done",     32'(prog_done), 32'd0);
        chk("rst fetch_count",   fetch_count, 32'd0);

        // IDLE: no requests, redirect ignored.
        doReset();
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); redirect = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle mem_addr", mem_addr, 32'h0);
        chk("idle req_valid", 32'(mem_req_valid), 32'd0);

        // Basic in-order fetch, 1-cycle memory.
        lat = 1; haltEn = 1'b0;
        doReset();
        @(negedge clk); pc_en = 1'b1;
        waitDel(3, 30, "basic deliveries");
        chk("basic fetch_count", fetch_count, 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("basic inst",    delInst[i], 32'h1000_0001 + 32'(i));
            chk("basic inst_pc", delPc[i], 32'(4 * i));
            chk("basic mem_addr", reqLog[i], 32'(4 * i));
        end

        // Backpressure: queue fills, requests stop, then resume at 0x10.
        doReset();
        readyReq = 1'b0;
        @(negedge clk); pc_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp req count", 32'(reqLog.size()), 32'd4);
        chk("bp last req", reqLog[3], 32'hC);
        chk("bp req_valid held", 32'(mem_req_valid), 32'd0);
        chk("bp inst_valid", 32'(inst_valid), 32'd1);
        chk("bp head inst", inst, 32'h1000_0001);
        readyReq = 1'b1;
        waitDel(4, 30, "bp deliveries");
        for (int i = 0; i < 4; i++) begin
            chk("bp inst", delInst[i], 32'h1000_0001 + 32'(i));
            chk("bp inst_pc", delPc[i], 32'(4 * i));
        end
        waitReq(5, 30, "bp resume");
        chk("bp resume addr", reqLog[4], 32'h10);

        // Redirect with two requests in flight, 3-cycle memory.
        lat = 3;
        doReset();
        @(negedge clk); pc_en = 1'b1;
        waitReq(2, 20, "redir setup");
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0203;
        #1 chk("redir req_valid forced", 32'(mem_req_valid), 32'd0);
        @(negedge clk); redirect = 1'b0;
        chk("redir mem_addr", mem_addr, 32'h200);
        waitDel(1, 40, "redir delivery");
        chk("redir first inst_pc", delPc[0], 32'h200);
        chk("redir first inst", delInst[0], 32'h1000_0081);
        chk("redir next req", reqLog[2], 32'h200);

        // Table-driven halt/drain runs.
        for (int v = 0; v < 5; v++) begin
            int n = 0;
            int bad = 0;
            int k;
            lat = vecs[v].lat; haltEn = 1'b1; haltAddr = vecs[v].haltAddr;
            doReset();
            throttle = vecs[v].throttle;
            @(negedge clk); pc_en = 1'b1;
            while (!prog_done && (n < 300)) begin @(negedge clk); n++; end
            chk("halt prog_done", 32'(prog_done), 32'd1);
            chk("halt fetch_count", fetch_count, 32'(vecs[v].expCount));
            chk("halt deliveries", 32'(delInst.size()), 32'(vecs[v].expCount));
            k = int'(vecs[v].haltAddr >> 2);
            for (int i = 0; i < delInst.size(); i++) begin
                if (i < k) begin
                    if (delInst[i] !== (32'h1000_0001 + 32'(i)) || delPc[i] !== 32'(4 * i)) bad++;
                end else begin
                    if (delInst[i] !== NOP || delPc[i] !== vecs[v].haltAddr) bad++;
                end
            end
            chk("halt delivery contents", 32'(bad), 32'd0);
            chk("halt no req after halt", 32'(reqAfterHalt), 32'd0);
            bad = 0;
            for (int i = 0; i < reqLog.size(); i++)
                if (reqLog[i] !== 32'(4 * i)) bad++;
            chk("halt req sequence", 32'(bad), 32'd0);
            @(negedge clk);
            chk("done inst_valid", 32'(inst_valid), 32'd0);
            chk("done req_valid", 32'(mem_req_valid), 32'd0);
        end

        // Asynchronous reset in the middle of DRAIN.
        begin
            int n = 0;
            lat = 1; haltEn = 1'b1; haltAddr = 32'h8;
            doReset();
            @(negedge clk); pc_en = 1'b1;
            while (!(inst_valid && inst === NOP && inst_pc === 32'h8) && (n < 50)) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 50) timeoutFail("drain entry");
            @(posedge clk); #3;
            reset = 1'b1;
            #1;
            chk("areset mem_req_valid", 32'(mem_req_valid), 32'd0);
            chk("areset mem_addr",      mem_addr, 32'h0);
            chk("areset inst_valid",    32'(inst_valid), 32'd0);
            chk("areset inst",          inst, 32'h0);
            chk("areset inst_pc",       inst_pc, 32'h0);
            chk("areset prog_done",     32'(prog_done), 32'd0);
            chk("areset fetch_count",   fetch_count, 32'd0);
            repeat (2) @(negedge clk);
            reqLog.delete(); delInst.delete(); delPc.delete();
            haltEn = 1'b0;
            reset = 1'b0;
            waitReq(1, 20, "rerun request");
            chk("rerun first addr", reqLog[0], 32'h0);
            chk("rerun prog_done", 32'(prog_done), 32'd0);
        end

        // Redirect and dequeue in the same cycle with two entries queued.
        lat = 1; haltEn = 1'b0;
        doReset();
        readyReq = 1'b0;
        @(negedge clk); pc_en = 1'b1;
        waitReq(2, 20, "rd+deq setup");
        @(negedge clk); pc_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("rd+deq req count", 32'(reqLog.size()), 32'd2);
        chk("rd+deq inst_valid before", 32'(inst_valid), 32'd1);
        readyReq = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        @(posedge clk); #1;
        chk("rd+deq fetch_count", fetch_count, 32'd0);
        chk("rd+deq inst_valid after", 32'(inst_valid), 32'd0);
        @(negedge clk); redirect = 1'b0;
        @(posedge clk); #1;
        chk("rd+deq queue empty", 32'(inst_valid), 32'd0);
        chk("rd+deq mem_addr", mem_addr, 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
